awgn_stats_monitor: RTL and testbench
=====================================

// Module: awgn_stats_monitor
// PURPOSE
//  Consumer end of the AWGN sample stream (x0, x1, v) from the Box-Muller generator.
//  Captures a window of 2^LOG2_WIN valid sample pairs and reports per-lane statistics:
//  mean, variance and peak magnitude.
//  Used in-system and on the bench to qualify generator output (mean ~0, variance ~target).
// PARAMETERS
//  SAMPLE_W   16  width of each signed input sample
//  LOG2_WIN   10  window length = 2^LOG2_WIN valid pairs (legal 1..16)
// PORTS
//  clk        in   1                  single clock, rising edge
//  reset      in   1                  synchronous, active-high; clears all state
//  start      in   1                  one-cycle pulse; begins a window when IDLE
//  x0         in   SAMPLE_W           signed sample, lane 0
//  x1         in   SAMPLE_W           signed sample, lane 1
//  v          in   1                  sample pair valid; no backpressure, pair taken when v=1
//  busy       out  1                  high from accepted start until done
//  done       out  1                  one-cycle pulse when results update
//  mean0      out  SAMPLE_W           signed mean, lane 0
//  mean1      out  SAMPLE_W           signed mean, lane 1
//  var0       out  2*SAMPLE_W         unsigned variance, lane 0
//  var1       out  2*SAMPLE_W         unsigned variance, lane 1
//  peak0      out  SAMPLE_W           max |x0| over window, saturated
//  peak1      out  SAMPLE_W           max |x1| over window, saturated
// BEHAVIOUR
//  Reset
//   - All outputs are 0; FSM in IDLE; accumulators and counter cleared.
//   - Reset mid-window abandons the window; outputs return to 0 (not held).
//  FSM: IDLE -> ACCUM -> DRAIN -> CALC_MEAN -> CALC_VAR -> DONE -> IDLE
//   - IDLE: start=1 clears accumulators, counter and peaks; next state ACCUM; busy=1 from next cycle.
//   - ACCUM: each cycle with v=1 registers the pair (stage 1). Stage 2 adds x to sum,
//     x*x to sumsq and updates peak.
//   - ACCUM: count increments per accepted pair. v=0 cycles are ignored; gaps of any length are legal.
//   - ACCUM exits to DRAIN in the cycle the (2^LOG2_WIN)-th pair is accepted. Further v in the same
//     window is not counted.
//   - DRAIN: 2 cycles, to flush stages 1-2. No samples are accepted.
//   - CALC_MEAN: mean = sum >>> LOG2_WIN (arithmetic, truncates toward -inf); registered.
//   - CALC_VAR: var = (sumsq >> LOG2_WIN) - mean*mean. A negative result clamps to 0.
//   - DONE: one cycle. done=1, busy=0 on the same edge the results load; then IDLE.
//  Latency: done rises exactly 5 cycles after the cycle that accepted the last pair.
//  Result hold: results hold until the next done or reset. start while busy is ignored.
//  start and v together in IDLE: that v is NOT part of the window; the window begins the next cycle.
//  Widths
//   - sum is SAMPLE_W+LOG2_WIN bits, signed.
//   - sumsq is 2*SAMPLE_W+LOG2_WIN bits, unsigned. Neither can overflow.
//   - The square is computed at full 2*SAMPLE_W width; mean*mean likewise.
//  Peak: |x| with |-2^(SAMPLE_W-1)| saturated to 2^(SAMPLE_W-1)-1.
// STRUCTURE
//  Package awgn_pkg
//   - SAMPLE_W default.
//   - FSM state encoding: ST_IDLE, ST_ACCUM, ST_DRAIN, ST_CALC_MEAN, ST_CALC_VAR, ST_DONE.
//   - Derived width constants: SUM_W, SQ_W.
//  Sub-module awgn_lane_accum, instantiated once per lane
//   - Contains the input register, square, sum/sumsq accumulators, peak tracker and mean/var datapath.
//   - Controlled by clr, en and calc strobes from the top-level FSM.
//  Top level holds the FSM, window counter, busy and done.
// TESTING (LOG2_WIN=4 unless noted)
//  1 Constant: start; 16 pairs x0=100, x1=-100, v=1 every cycle
//    -> mean0=100, mean1=-100, var0=var1=0, peak0=peak1=100; done 5 cycles after 16th pair.
//  2 Alternating: x0=+1000/-1000, x1=-1000/+1000, with random v gaps of 0-7 cycles
//    -> mean=0, var=1000000 on both lanes; busy stays high across gaps.
//  3 Saturation: one x0=-32768, the rest 0
//    -> peak0=32767, mean0=-2048, var0=(2^30>>4)-2048^2=62914560.
//  4 Protocol: start pulsed again mid-ACCUM; 17 consecutive valid pairs
//    -> second start ignored; 17th pair excluded; exactly one done pulse.
//  5 Reset mid-window: reset after 8 pairs, then start and a full window of x0=x1=5
//    -> all outputs 0 during and after reset; final mean=5, var=0.
//  6 Generator loopback: LOG2_WIN=10 driven by the Box-Muller generator
//    -> |mean| within 3 sigma of 0; var within 10% of the golden-model value.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN statistics monitor: default widths, FSM
// encoding and helpers deriving accumulator widths from the window length.
package awgn_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int LOG2_WIN_DEF = 10;
    localparam int SUM_W        = SAMPLE_W_DEF + LOG2_WIN_DEF;
    localparam int SQ_W         = 2 * SAMPLE_W_DEF + LOG2_WIN_DEF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCUM     = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_CALC_MEAN = 3'd3,
        ST_CALC_VAR  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // A sum of 2^lw signed samples grows by lw bits and cannot overflow.
    function automatic int sum_width(input int sw, input int lw);
        return sw + lw;
    endfunction

    function automatic int sq_width(input int sw, input int lw);
        return 2 * sw + lw;
    endfunction

endpackage

// File: rtl/awgn_lane_accum.sv
// One lane of the statistics datapath: input register, square, sum/sumsq
// accumulators, saturating peak tracker, then mean and variance registers.
module awgn_lane_accum
    import awgn_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int LOG2_WIN = LOG2_WIN_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       calc_mean,
    input  logic                       calc_var,
    input  logic                       load,
    input  logic signed [SAMPLE_W-1:0] x,
    output logic signed [SAMPLE_W-1:0] mean,
    output logic [2*SAMPLE_W-1:0]      variance,
    output logic [SAMPLE_W-1:0]        peak
);

    localparam int SUM_BITS = sum_width(SAMPLE_W, LOG2_WIN);
    localparam int SQ_BITS  = sq_width(SAMPLE_W, LOG2_WIN);
    localparam int PROD_W   = 2 * SAMPLE_W;
    localparam logic [SAMPLE_W-1:0] MAX_MAG = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] ONE     = SAMPLE_W'(1);

    logic signed [SAMPLE_W-1:0] s1_x;
    logic                       s1_v;
    logic signed [SUM_BITS-1:0] sum;
    logic [SQ_BITS-1:0]         sumsq;
    logic [SAMPLE_W-1:0]        peak_r;
    logic signed [SAMPLE_W-1:0] mean_r;
    logic [PROD_W-1:0]          var_r;

    logic signed [PROD_W-1:0]   sq;
    logic [SAMPLE_W-1:0]        mag;
    logic [PROD_W-1:0]          sq_avg;
    logic [PROD_W-1:0]          mean_sq;
    logic [PROD_W:0]            var_diff;
    logic [PROD_W-1:0]          var_next;

    assign sq      = s1_x * s1_x;
    assign sq_avg  = PROD_W'(sumsq >> LOG2_WIN);
    assign mean_sq = mean_r * mean_r;

    // Most negative input has no positive twin; it saturates to full scale.
    always_comb begin
        mag = s1_x;
        if (s1_x[SAMPLE_W-1]) begin
            if (s1_x[SAMPLE_W-2:0] == '0) begin
                mag = MAX_MAG;
            end else begin
                mag = ~s1_x + ONE;
            end
        end
    end

    // 33-bit difference: its top bit flags a negative variance from truncation.
    always_comb begin
        var_diff = {1'b0, sq_avg} - {1'b0, mean_sq};
        var_next = var_diff[PROD_W] ? '0 : var_diff[PROD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_x   <= '0;
            s1_v   <= 1'b0;
            sum    <= '0;
            sumsq  <= '0;
            peak_r <= '0;
            mean_r <= '0;
            var_r  <= '0;
        end else if (clr) begin
            s1_v   <= 1'b0;
            sum    <= '0;
            sumsq  <= '0;
            peak_r <= '0;
            mean_r <= '0;
            var_r  <= '0;
        end else begin
            s1_v <= en;
            if (en) begin
                s1_x <= x;
            end
            if (s1_v) begin
                sum   <= sum + {{LOG2_WIN{s1_x[SAMPLE_W-1]}}, s1_x};
                sumsq <= sumsq + {{LOG2_WIN{1'b0}}, sq};
                if (mag > peak_r) begin
                    peak_r <= mag;
                end
            end
            if (calc_mean) begin
                mean_r <= SAMPLE_W'(sum >>> LOG2_WIN);
            end
            if (calc_var) begin
                var_r <= var_next;
            end
        end
    end

    // Visible results change only when a window completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mean     <= '0;
            variance <= '0;
            peak     <= '0;
        end else if (load) begin
            mean     <= mean_r;
            variance <= var_r;
            peak     <= peak_r;
        end
    end

endmodule

// File: rtl/awgn_stats_monitor.sv
// Window-based mean/variance/peak monitor for a two-lane AWGN sample stream.
// Top level: control FSM, window counter, busy/done; datapath lives per lane.
module awgn_stats_monitor
    import awgn_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int LOG2_WIN = LOG2_WIN_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [SAMPLE_W-1:0] x0,
    input  logic signed [SAMPLE_W-1:0] x1,
    input  logic                       v,
    output logic                       busy,
    output logic                       done,
    output logic signed [SAMPLE_W-1:0] mean0,
    output logic signed [SAMPLE_W-1:0] mean1,
    output logic [2*SAMPLE_W-1:0]      var0,
    output logic [2*SAMPLE_W-1:0]      var1,
    output logic [SAMPLE_W-1:0]        peak0,
    output logic [SAMPLE_W-1:0]        peak1
);

    localparam logic [LOG2_WIN-1:0] LAST_IDX = {LOG2_WIN{1'b1}};

    // Stream handshake: v alone qualifies a pair; there is no ready, so a pair
    // presented with v=1 is consumed in that cycle if the FSM is in ACCUM and
    // silently dropped in any other state.
    state_t              state;
    state_t              state_nx;
    logic [LOG2_WIN-1:0] count;
    logic                drain_cnt;
    logic                clr;
    logic                en;
    logic                calc_mean;
    logic                calc_var;
    logic                load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        en        = 1'b0;
        calc_mean = 1'b0;
        calc_var  = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (v) begin
                    en = 1'b1;
                    if (count == LAST_IDX) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) begin
                    state_nx = ST_CALC_MEAN;
                end
            end
            ST_CALC_MEAN: begin
                calc_mean = 1'b1;
                state_nx  = ST_CALC_VAR;
            end
            ST_CALC_VAR: begin
                calc_var = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                load     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // drain_cnt is 0 on DRAIN entry, so DRAIN lasts exactly two cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= load;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
            if (clr) begin
                count <= '0;
                busy  <= 1'b1;
            end else if (en) begin
                count <= count + LOG2_WIN'(1);
            end
            if (load) begin
                busy <= 1'b0;
            end
        end
    end

    awgn_lane_accum #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (en),
        .calc_mean (calc_mean),
        .calc_var  (calc_var),
        .load      (load),
        .x         (x0),
        .mean      (mean0),
        .variance  (var0),
        .peak      (peak0)
    );

    awgn_lane_accum #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (en),
        .calc_mean (calc_mean),
        .calc_var  (calc_var),
        .load      (load),
        .x         (x1),
        .mean      (mean1),
        .variance  (var1),
        .peak      (peak1)
    );

endmodule

// File: tb/tb_awgn_stats_monitor.sv
// Bench for awgn_stats_monitor with a 16-pair window: constant-window table,
// hand-written protocol sequences and random windows against an arithmetic model.
module tb_awgn_stats_monitor;

    localparam int SW  = 16;
    localparam int LW  = 4;
    localparam int WIN = 1 << LW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic v     = 1'b0;
    logic signed [SW-1:0] x0 = '0;
    logic signed [SW-1:0] x1 = '0;
    logic busy;
    logic done;
    logic signed [SW-1:0] mean0;
    logic signed [SW-1:0] mean1;
    logic [2*SW-1:0] var0;
    logic [2*SW-1:0] var1;
    logic [SW-1:0] peak0;
    logic [SW-1:0] peak1;

    awgn_stats_monitor #(.SAMPLE_W(SW), .LOG2_WIN(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x0    (x0),
        .x1    (x1),
        .v     (v),
        .busy  (busy),
        .done  (done),
        .mean0 (mean0),
        .mean1 (mean1),
        .var0  (var0),
        .var1  (var1),
        .peak0 (peak0),
        .peak1 (peak1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [127:0] exp_q[$];
    logic signed [SW-1:0] win0[$];
    logic signed [SW-1:0] win1[$];

    typedef struct {
        int    x0;
        int    x1;
        longint m0;
        longint m1;
        longint v0;
        longint v1;
        longint p0;
        longint p1;
    } vec_t;
    vec_t tbl[4];

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input longint m0, input longint m1, input longint v0,
                                     input longint v1, input longint p0, input longint p1);
        exp_q.push_back({16'(m0), 16'(m1), 32'(v0), 32'(v1), 16'(p0), 16'(p1)});
    endfunction

    // Reference: plain arithmetic on the captured window.
    function automatic void lane_stats(input int lane, output longint m, output longint va,
                                       output longint pk);
        longint s = 0;
        longint q = 0;
        longint a;
        longint x;
        pk = 0;
        for (int i = 0; i < WIN; i++) begin
            x = (lane == 0) ? longint'(win0[i]) : longint'(win1[i]);
            s += x;
            q += x * x;
            a = (x < 0) ? -x : x;
            if (a > 32767) a = 32767;
            if (a > pk) pk = a;
        end
        m = s / WIN;
        if ((s % WIN) != 0 && s < 0) m -= 1;
        va = q / WIN - m * m;
        if (va < 0) va = 0;
    endfunction

    function automatic void model_push();
        longint m0, v0, p0, m1, v1, p1;
        lane_stats(0, m0, v0, p0);
        lane_stats(1, m1, v1, p1);
        push_exp(m0, m1, v0, v1, p0, p1);
    endfunction

    logic [127:0] e;
    logic signed [SW-1:0] em0, em1;
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done_queue_size", longint'(exp_q.size()), 1);
            end else begin
                e   = exp_q.pop_front();
                em0 = e[127:112];
                em1 = e[111:96];
                check("mean0", mean0, em0);
                check("mean1", mean1, em1);
                check("var0", var0, e[95:64]);
                check("var1", var1, e[63:32]);
                check("peak0", peak0, e[31:16]);
                check("peak1", peak1, e[15:0]);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b,
                             input int gap);
        v = 1'b0;
        repeat (gap) tick();
        v  = 1'b1;
        x0 = a;
        x1 = b;
        tick();
        v = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic run_window(input int max_gap);
        int lat;
        pulse_start();
        for (int i = 0; i < WIN; i++) begin
            send_pair(win0[i], win1[i], $urandom_range(0, max_gap));
        end
        wait_done(lat);
        check("latency", lat, 5);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mean0"}, mean0, 0);
        check({tag, "_mean1"}, mean1, 0);
        check({tag, "_var0"}, var0, 0);
        check({tag, "_var1"}, var1, 0);
        check({tag, "_peak0"}, peak0, 0);
        check({tag, "_peak1"}, peak1, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int d0;

        tbl[0] = '{100, -100, 100, -100, 0, 0, 100, 100};
        tbl[1] = '{-32768, 32767, -32768, 32767, 0, 0, 32767, 32767};
        tbl[2] = '{-1, 0, -1, 0, 0, 0, 1, 0};
        tbl[3] = '{12345, -7, 12345, -7, 0, 0, 12345, 7};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_outputs_zero("reset");

        // Constant windows; entry 0 streams back-to-back with no gaps.
        for (int t = 0; t < 4; t++) begin
            win0.delete();
            win1.delete();
            for (int i = 0; i < WIN; i++) begin
                win0.push_back(16'(tbl[t].x0));
                win1.push_back(16'(tbl[t].x1));
            end
            push_exp(tbl[t].m0, tbl[t].m1, tbl[t].v0, tbl[t].v1, tbl[t].p0, tbl[t].p1);
            run_window((t == 0) ? 0 : 2);
            tick();
        end

        // Alternating +/-1000 with gaps up to 7 cycles.
        push_exp(0, 0, 1000000, 1000000, 1000, 1000);
        pulse_start();
        for (int i = 0; i < WIN; i++) begin
            send_pair((i % 2 == 0) ? 16'sd1000 : -16'sd1000,
                      (i % 2 == 0) ? -16'sd1000 : 16'sd1000, $urandom_range(0, 7));
            if (i == 5) begin
                repeat (7) tick();
                check("busy_in_gap", busy, 1);
            end
        end
        wait_done(lat);
        check("latency_alt", lat, 5);
        tick();

        // Single most-negative sample on lane 0.
        win0.delete();
        win1.delete();
        for (int i = 0; i < WIN; i++) begin
            win0.push_back((i == 3) ? -16'sd32768 : 16'sd0);
            win1.push_back(16'sd0);
        end
        push_exp(-2048, 0, 62914560, 0, 32767, 0);
        run_window(1);
        tick();

        // start together with v in IDLE: that pair must stay out of the window.
        push_exp(7, -7, 0, 0, 7, 7);
        v = 1'b1;
        x0 = 16'sd9999;
        x1 = -16'sd9999;
        pulse_start();
        v = 1'b0;
        for (int i = 0; i < WIN; i++) send_pair(16'sd7, -16'sd7, 0);
        wait_done(lat);
        check("latency_start_v", lat, 5);
        tick();

        // Second start mid-window and a 17th back-to-back pair.
        win0.delete();
        win1.delete();
        for (int i = 0; i < WIN; i++) begin
            win0.push_back(16'($urandom_range(0, 65535)));
            win1.push_back(16'($urandom_range(0, 65535)));
        end
        model_push();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i <= WIN; i++) begin
            if (i == 8) start = 1'b1;
            if (i < WIN) send_pair(win0[i], win1[i], 0);
            else send_pair(16'sd30000, -16'sd30000, 0);
            start = 1'b0;
        end
        wait_done(lat);
        check("latency_after_17th", lat, 4);
        repeat (12) tick();
        check("single_done", done_cnt - d0, 1);
        check("idle_busy", busy, 0);

        // Reset mid-window, then a fresh window.
        pulse_start();
        for (int i = 0; i < 8; i++) send_pair(16'sd1234, -16'sd4321, 0);
        reset = 1'b1;
        tick();
        check_outputs_zero("in_reset");
        tick();
        reset = 1'b0;
        tick();
        check_outputs_zero("after_reset");
        win0.delete();
        win1.delete();
        for (int i = 0; i < WIN; i++) begin
            win0.push_back(16'sd5);
            win1.push_back(16'sd5);
        end
        push_exp(5, 5, 0, 0, 5, 5);
        run_window(1);
        tick();

        // Random windows against the model.
        for (int r = 0; r < 8; r++) begin
            win0.delete();
            win1.delete();
            for (int i = 0; i < WIN; i++) begin
                win0.push_back(16'($urandom_range(0, 65535)));
                win1.push_back(16'($urandom_range(0, 65535)) >>> $urandom_range(0, 8));
            end
            model_push();
            run_window(3);
            tick();
        end

        repeat (5) tick();
        check("exp_q_drained", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
